// File: rtl/sega_rom_fetch.sv
// rtl/sega_rom_fetch.sv - program-ROM byte fetch through a direct-mapped word cache
module sega_rom_fetch #(
    parameter int INDEX_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [14:0] rom_addr,
    output logic [7:0]  rom_do,
    output logic        rom_valid,
    input  logic        flush,
    output logic        sd_req,
    output logic [13:0] sd_addr,
    input  logic [15:0] sd_data,
    input  logic        sd_ack
);
    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = 14 - INDEX_W;

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t                r_state;
    logic [LINES-1:0]      r_valid;
    logic [TAG_W-1:0]      r_tag  [LINES];
    logic [15:0]           r_data [LINES];
    logic                  r_drop;
    logic                  r_sd_req;
    logic [13:0]           r_sd_addr;
    logic [7:0]            r_rom_do;
    logic                  r_rom_valid;

    logic [INDEX_W-1:0]    w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic [15:0]           w_word;
    logic                  w_hit;
    logic [INDEX_W-1:0]    w_fill_idx;
    logic [TAG_W-1:0]      w_fill_tag;

    assign w_idx      = rom_addr[INDEX_W:1];
    assign w_tag      = rom_addr[14:INDEX_W+1];
    assign w_word     = r_data[w_idx];
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    // The fill target comes from the frozen request address, not the live rom_addr.
    assign w_fill_idx = r_sd_addr[INDEX_W-1:0];
    assign w_fill_tag = r_sd_addr[13:INDEX_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_valid     <= '0;
            r_drop      <= 1'b0;
            r_sd_req    <= 1'b0;
            r_sd_addr   <= '0;
            r_rom_do    <= 8'h00;
            r_rom_valid <= 1'b0;
            for (int i = 0; i < LINES; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        r_rom_do    <= rom_addr[0] ? w_word[15:8] : w_word[7:0];
                        r_rom_valid <= 1'b1;
                    end else begin
                        r_rom_valid <= 1'b0;
                        r_sd_addr   <= rom_addr[14:1];
                        r_sd_req    <= 1'b1;
                        r_state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    r_rom_valid <= 1'b0;
                    if (sd_ack) begin
                        r_data[w_fill_idx] <= sd_data;
                        r_tag[w_fill_idx]  <= w_fill_tag;
                        if (!r_drop)
                            r_valid[w_fill_idx] <= 1'b1;
                        r_sd_req <= 1'b0;
                        r_drop   <= 1'b0;
                        r_state  <= S_IDLE;
                    end else if (flush) begin
                        r_drop <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            // Placed last so a flush overrides a fill landing in the same cycle.
            if (flush)
                r_valid <= '0;
        end
    end

    assign rom_do    = r_rom_do;
    assign rom_valid = r_rom_valid;
    assign sd_req    = r_sd_req;
    assign sd_addr   = r_sd_addr;
endmodule

// File: doc/sega_rom_fetch.md
# sega_rom_fetch

Program-ROM fetch stage that sits directly upstream of the opcode decryptor. It serves the decryptor's 15-bit byte address from a 16-bit-wide external memory port (SDRAM controller) through a small direct-mapped word cache. Each byte is returned on a registered data bus with a validity flag. Misses use a level request / pulse acknowledge handshake toward the memory controller.

## Interface
Parameters:
- INDEX_W, default 2: cache index width; 2^INDEX_W lines, one 16-bit word per line.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- rom_addr  in  15  byte address from decryptor (cpu_rom_addr).
- rom_do  out  8  byte for rom_addr sampled previous cycle (to decryptor cpu_rom_do).
- rom_valid  out  1  rom_do holds correct byte for rom_addr sampled previous cycle.
- flush  in  1  invalidate all lines (pulse after ROM download or bank change).
- sd_req  out  1  level request; held high until sd_ack.
- sd_addr  out  14  word address = rom_addr[14:1] of the missing byte; stable while sd_req high.
- sd_data  in  16  word from memory; valid only in the sd_ack cycle; low byte = even address.
- sd_ack  in  1  one-cycle completion pulse.

## Operation
- Line fields: index = rom_addr[INDEX_W:1], tag = rom_addr[14:INDEX_W+1], 16-bit data, valid bit.
- Hit = line[index].valid and tag match. Byte select: rom_addr[0]=0 → data[7:0], 1 → data[15:8].
- FSM, two states:
  - IDLE: lookup every cycle. On hit, register selected byte into rom_do and set rom_valid=1. On miss, set rom_valid=0, latch sd_addr=rom_addr[14:1], set sd_req=1, go to REQ.
  - REQ: rom_valid=0, sd_req=1, and sd_addr frozen; rom_addr changes are ignored. On sd_ack, write sd_data into line[sd_addr index], write the tag and set valid unless a drop is pending. Then set sd_req=0, clear drop, and go to IDLE.
- flush: clears all valid bits at the edge, and has priority over a fill in the same cycle. If flush arrives in REQ, set the drop flag; the outstanding fill then completes the handshake but is not marked valid.
- sd_ack outside REQ is ignored. A miss is re-evaluated in IDLE after the fill, so an address change during REQ causes a second miss if needed.
- Reset values: state IDLE, all valid bits 0, drop 0, sd_req 0, sd_addr 0, rom_do 0x00, rom_valid 0. Reset mid-REQ abandons the request; a late sd_ack is ignored.

## Timing
- Hit latency: rom_addr presented in cycle N → rom_do and rom_valid valid in cycle N+1. Back-to-back hits give one byte per cycle.
- Miss: address sampled in cycle N → sd_req high in N+1. sd_ack in cycle M (M ≥ N+1) → line written at end of M, sd_req low in M+1, IDLE lookup hits in M+1, rom_valid=1 in M+2.
- Minimum miss penalty with same-cycle ack at N+1: rom_valid in N+3.
- rom_valid is never high while state is REQ.
- The decryptor samples the address every other clock, so a hit satisfies it within its phase. The decryptor-side stall is the integrator's responsibility.

## Test plan
- Reset, then rom_addr=0x0000 → sd_req=1 and sd_addr=0x0000 in next cycle. Ack with sd_data=0xA53C → rom_do=0x3C, rom_valid=1 two cycles after ack. Then rom_addr=0x0001 → rom_do=0xA5 next cycle, no sd_req.
- Conflict miss (INDEX_W=2): fill 0x0002 with 0x1122, then access 0x0012 (same index, different tag) → new sd_req with sd_addr=0x0009. Ack 0x3344, then 0x0002 → misses again.
- Address change during REQ: miss 0x0100, change rom_addr to 0x0200 before ack → sd_addr stays 0x0080. After ack, second request with sd_addr=0x0100.
- Flush in REQ: miss 0x0040, pulse flush, ack 0x7788 → sd_req drops, then re-request 0x0020 because the line is invalid. Separately, flush and ack in the same cycle → line not valid.
- Reset asserted asynchronously with sd_req high → sd_req, rom_valid, and rom_do go 0 immediately. A stray sd_ack afterwards causes no fill; the next access to the prior address misses.
- Streaming hits: fill four lines, sweep addresses 0x0000–0x0007 every cycle → rom_valid continuously 1 and bytes match filled words in order.
